// File: rtl/slab_interval_reducer.sv
// slab_interval_reducer
//   Ray/AABB slab reduction stage. Accepts one (tnear, tfar) pair per axis in
//   FloPoCo word format and keeps running tmin = max(tnear) and tmax = min(tfar).
//   Once NAXES pairs have been absorbed, it produces
//   hit = (tmin <= tmax) && (tmax >= 0). The result is held until the consumer
//   accepts it.
//
//   Word layout: [width:width-1] exc (00 zero, 01 normal, 10 inf, 11 NaN),
//   [width-2] sign, then exponent and fraction.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     in_valid   tnear/tfar valid
//     in_ready   a pair is accepted this cycle (registered)
//     tnear      near slab distance
//     tfar       far slab distance
//     out_valid  result valid
//     out_ready  result consumed
//     out_hit    ray hits box
//     out_tmin   reduced entry distance
//     out_tmax   reduced exit distance
//     out_nan    sticky NaN seen in this ray (only with RAABB_NAN_FLAG_EN)
//
//   Build option: define RAABB_NAN_FLAG_EN to expose out_nan.

module slab_interval_reducer #(
    parameter int width = 22,
    parameter int NAXES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width:0]   tnear,
    input  logic [width:0]   tfar,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [width:0]   out_tmin,
    output logic [width:0]   out_tmax
`ifdef RAABB_NAN_FLAG_EN
    ,
    output logic             out_nan
`endif
);

    localparam int CW = (NAXES > 1) ? $clog2(NAXES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACC, EVAL, OUT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt;
    logic [width:0]  tmin, tmax;
    logic            nan;
    logic            accept;
    logic            hit_now;

    // Signed order key. Normal magnitudes carry a leading 0 so that inf
    // (all ones) sorts strictly above every finite value; +0 and -0 share key 0.
    function automatic logic signed [width:0] order_key(input logic [width:0] w);
        logic [width-1:0]   mag;
        logic signed [width:0] k;
        case (w[width -: 2])
            2'b00:   mag = '0;
            2'b01:   mag = {2'b01, w[width-3:0]};
            default: mag = '1;
        endcase
        k = $signed({1'b0, mag});
        return w[width-2] ? -k : k;
    endfunction

    function automatic logic lt(input logic [width:0] a, input logic [width:0] b);
        return order_key(a) < order_key(b);
    endfunction

    function automatic logic is_nan(input logic [width:0] w);
        return w[width -: 2] == 2'b11;
    endfunction

    assign accept  = in_valid && in_ready;
    assign hit_now = !nan && !lt(tmax, tmin) && !lt(tmax, '0);

    // State register; in_ready is registered from the next state so that it
    // reads 0 while in reset and during EVAL/OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d == IDLE) || (state_d == ACC);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (NAXES == 1) ? EVAL : ACC;
            ACC:  if (accept && (cnt == CW'(NAXES - 1))) state_d = EVAL;
            EVAL: state_d = OUT;
            OUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            tmin      <= '0;
            tmax      <= '0;
            nan       <= 1'b0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_tmin  <= '0;
            out_tmax  <= '0;
`ifdef RAABB_NAN_FLAG_EN
            out_nan   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tmin <= tnear;
                        tmax <= tfar;
                        cnt  <= CW'(1);
                        nan  <= is_nan(tnear) || is_nan(tfar);
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (lt(tmin, tnear)) tmin <= tnear;
                        if (lt(tfar, tmax))  tmax <= tfar;
                        nan <= nan || is_nan(tnear) || is_nan(tfar);
                        cnt <= cnt + CW'(1);
                    end
                end
                EVAL: begin
                    out_hit   <= hit_now;
                    out_tmin  <= tmin;
                    out_tmax  <= tmax;
                    out_valid <= 1'b1;
`ifdef RAABB_NAN_FLAG_EN
                    out_nan   <= nan;
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= '0;
                        nan       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slab_interval_reducer.sv
// Testbench for slab_interval_reducer: directed vector table, reset/handshake
// sequences, and randomized rays checked against a real-valued reference model.

module tb_slab_interval_reducer;

    localparam int W = 22;
    localparam int N = 3;

    localparam logic [W:0] PZ   = 23'h000000;
    localparam logic [W:0] NZ   = 23'h100000;
    localparam logic [W:0] ONE  = 23'h27FE00;
    localparam logic [W:0] HALF = 23'h27FC00;
    localparam logic [W:0] TWO  = 23'h280000;
    localparam logic [W:0] THR  = 23'h280100;
    localparam logic [W:0] FOUR = 23'h280200;
    localparam logic [W:0] FIVE = 23'h280280;
    localparam logic [W:0] M1   = 23'h37FE00;
    localparam logic [W:0] M2   = 23'h380000;
    localparam logic [W:0] M3   = 23'h380100;
    localparam logic [W:0] M5   = 23'h380280;
    localparam logic [W:0] PINF = 23'h400000;
    localparam logic [W:0] NINF = 23'h500000;
    localparam logic [W:0] QNAN = 23'h600000;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, out_hit;
    logic [W:0] tnear, tfar, out_tmin, out_tmax;
`ifdef RAABB_NAN_FLAG_EN
    logic out_nan;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    slab_interval_reducer #(.width(W), .NAXES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .tnear(tnear), .tfar(tfar), .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_tmin(out_tmin), .out_tmax(out_tmax)
`ifdef RAABB_NAN_FLAG_EN
        , .out_nan(out_nan)
`endif
    );

    typedef struct {
        logic [N-1:0][W:0] tn;
        logic [N-1:0][W:0] tf;
        logic              hit;
        logic [W:0]        tmin;
        logic [W:0]        tmax;
        logic              nan;
        logic              chk_vals;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0][W:0] mk3(input logic [W:0] a, input logic [W:0] b, input logic [W:0] c);
        return {c, b, a};
    endfunction

    // Reference model: decode each word to a real number and reduce.
    function automatic logic is_nan_w(input logic [W:0] w);
        return w[W -: 2] == 2'b11;
    endfunction

    function automatic real val(input logic [W:0] w);
        real m;
        case (w[W -: 2])
            2'b00:   m = 0.0;
            2'b01:   m = (1.0 + real'(w[8:0]) / 512.0) * (2.0 ** (real'(int'(w[19:9])) - 1023.0));
            default: m = 1.0e300;
        endcase
        return w[W-2] ? -m : m;
    endfunction

    task automatic model(input logic [N-1:0][W:0] tn, input logic [N-1:0][W:0] tf,
                         output logic hit, output logic [W:0] mn, output logic [W:0] mx,
                         output logic nan);
        mn = tn[0];
        mx = tf[0];
        nan = 1'b0;
        for (int i = 0; i < N; i++) begin
            nan = nan | is_nan_w(tn[i]) | is_nan_w(tf[i]);
            if (i > 0) begin
                if (val(tn[i]) > val(mn)) mn = tn[i];
                if (val(tf[i]) < val(mx)) mx = tf[i];
            end
        end
        hit = !nan && (val(mx) >= val(mn)) && (val(mx) >= 0.0);
    endtask

    function automatic logic [W:0] rnd_word(input int neg_pct);
        int r;
        logic s;
        logic [10:0] e;
        logic [8:0] f;
        r = $urandom_range(0, 99);
        s = ($urandom_range(0, 99) < neg_pct);
        if (r < 6)       return {2'b00, s, 20'h0};
        else if (r < 11) return {2'b10, s, 20'h0};
        else if (r < 13) return QNAN;
        e = 11'(1021 + $urandom_range(0, 4));
        f = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 3) << 7) : 9'($urandom);
        return {2'b01, s, e, f};
    endfunction

    task automatic feed_ray(input logic [N-1:0][W:0] tn, input logic [N-1:0][W:0] tf,
                            input int max_gap, output bit ok);
        bit acc;
        int gap;
        ok = 1;
        for (int i = 0; i < N; i++) begin
            gap = $urandom_range(0, max_gap);
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            tnear = tn[i];
            tfar = tf[i];
            acc = 0;
            for (int n = 0; n < 20 && !acc; n++) begin
                if (in_ready) acc = 1;
                @(negedge clk);
            end
            in_valid = 1'b0;
            if (!acc) begin
                check("accept_timeout", 0, 1);
                ok = 0;
                break;
            end
        end
    endtask

    // Called at the falling edge right after the final accept.
    task automatic collect_ray(input logic hit_e, input logic [W:0] mn_e, input logic [W:0] mx_e,
                               input logic nan_e, input logic chk_vals, input int hold);
        int lat = 0;
        check("in_ready_eval", in_ready, 0);
        check("valid_eval", out_valid, 0);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 1);
        if (!out_valid) return;
        for (int c = 0; c <= hold; c++) begin
            check("hit", out_hit, hit_e);
            if (chk_vals) begin
                check("tmin", out_tmin, mn_e);
                check("tmax", out_tmax, mx_e);
            end
`ifdef RAABB_NAN_FLAG_EN
            check("nan_flag", out_nan, nan_e);
`else
            if (c == 0 && nan_e) check("nan_forces_miss", out_hit, 0);
`endif
            if (c > 0) begin
                check("hold_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
            end
            if (c < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
    endtask

    logic [N-1:0][W:0] rtn, rtf;
    logic m_hit, m_nan;
    logic [W:0] m_mn, m_mx;
    bit ok;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mk3(ONE, TWO, HALF),  mk3(FOUR, FIVE, THR),  1'b1, TWO,  THR,  1'b0, 1'b1};
        vecs[1] = '{mk3(ONE, THR, PZ),    mk3(TWO, FOUR, FIVE),  1'b0, THR,  TWO,  1'b0, 1'b1};
        vecs[2] = '{mk3(M5, M5, M5),      mk3(M1, M1, M1),       1'b0, M5,   M1,   1'b0, 1'b1};
        vecs[3] = '{mk3(NZ, M1, M2),      mk3(PZ, PZ, PINF),     1'b1, NZ,   PZ,   1'b0, 1'b1};
        vecs[4] = '{mk3(ONE, TWO, HALF),  mk3(FOUR, QNAN, THR),  1'b0, PZ,   PZ,   1'b1, 1'b0};
        vecs[5] = '{mk3(ONE, TWO, HALF),  mk3(TWO, THR, TWO),    1'b1, TWO,  TWO,  1'b0, 1'b1};
        vecs[6] = '{mk3(M1, M2, M3),      mk3(NZ, ONE, FIVE),    1'b1, M1,   NZ,   1'b0, 1'b1};
        vecs[7] = '{mk3(NINF, ONE, NINF), mk3(PINF, PINF, TWO),  1'b1, ONE,  TWO,  1'b0, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tnear = '0;
        tfar = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_hit", out_hit, 0);
        check("rst_out_tmin", out_tmin, 0);
        check("rst_out_tmax", out_tmax, 0);
`ifdef RAABB_NAN_FLAG_EN
        check("rst_out_nan", out_nan, 0);
`endif
        rst = 1'b0;

        // Directed table; outputs held 5 cycles with out_ready low.
        for (int v = 0; v < 8; v++) begin
            feed_ray(vecs[v].tn, vecs[v].tf, (v == 1) ? 2 : 0, ok);
            if (ok) collect_ray(vecs[v].hit, vecs[v].tmin, vecs[v].tmax, vecs[v].nan, vecs[v].chk_vals, 5);
        end

        // Reset after two accepts, then a clean ray.
        rtn = mk3(FIVE, FIVE, HALF);
        rtf = mk3(ONE, ONE, THR);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tnear = rtn[i];
            tfar = rtf[i];
            for (int n = 0; n < 5 && !in_ready; n++) @(negedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midray_rst_in_ready", in_ready, 0);
        check("midray_rst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        feed_ray(vecs[0].tn, vecs[0].tf, 0, ok);
        if (ok) collect_ray(1'b1, TWO, THR, 1'b0, 1'b1, 1);

        // Reset while the result is being held.
        feed_ray(vecs[0].tn, vecs[0].tf, 0, ok);
        for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("out_rst_valid", out_valid, 0);
        check("out_rst_hit", out_hit, 0);
        check("out_rst_tmin", out_tmin, 0);
        check("out_rst_tmax", out_tmax, 0);
        @(negedge clk);
        rst = 1'b0;
        feed_ray(vecs[1].tn, vecs[1].tf, 1, ok);
        if (ok) collect_ray(1'b0, THR, TWO, 1'b0, 1'b1, 0);

        // Randomized rays against the reference model.
        for (int r = 0; r < 150; r++) begin
            for (int i = 0; i < N; i++) begin
                rtn[i] = rnd_word(50);
                rtf[i] = rnd_word(25);
            end
            model(rtn, rtf, m_hit, m_mn, m_mx, m_nan);
            feed_ray(rtn, rtf, 2, ok);
            if (ok) collect_ray(m_hit, m_mn, m_mx, m_nan, !m_nan, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
